bram_sdp: RTL and testbench
===========================

Name: bram_sdp

Overview:
Parametrised simple dual-port block RAM: one write port and one read port on a single clock. Next generation of the packet router's basic BRAM, adding:
- per-byte write enables
- selectable read-during-write behaviour
- a 1- or 2-cycle read latency with a registered output stage
- an rvalid strobe so consumers need not track latency themselves

Used for packet buffers and lookup tables.

Parameters:
DATA_WIDTH, 32, read/write data width in bits; must be a multiple of 8
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH words
READ_LATENCY, 1, cycles from accepted read to rdata/rvalid; legal values 1 or 2
RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new data (byte-merged bypass)

Ports:
clk     input   1                clock; all logic on rising edge
rst     input   1                synchronous, active-high reset
we      input   1                write enable
wbe     input   DATA_WIDTH/8     byte-lane write enables; bit i covers wdata[8i+7:8i]
waddr   input   ADDR_WIDTH       write address
wdata   input   DATA_WIDTH       write data
re      input   1                read enable
raddr   input   ADDR_WIDTH       read address
rdata   output  DATA_WIDTH       read data
rvalid  output  1                one-cycle strobe: rdata holds the result of a read

Behaviour:
Interface and reset
- One clock (clk). Reset rst is synchronous and active-high.
- Elaboration error if DATA_WIDTH%8 != 0 or READ_LATENCY is not 1 or 2.
- While rst=1: rdata=0, rvalid=0, and every internal valid/pipeline register is 0.
- Memory array is never reset. Contents survive rst.
- we and re are ignored in any cycle with rst=1: no write occurs and no read is issued.
- Reset mid-operation: reads accepted before rst rose produce no rvalid after rst. In-flight pipeline stages are flushed.

Write port
- At a clock edge with we=1 and rst=0: for each i with wbe[i]=1, mem[waddr] byte i <= wdata byte i.
- Lanes with wbe[i]=0 keep their value.
- we=1 with wbe all zero is a legal no-op.

Read port
- A read is accepted at edge N when re=1 and rst=0.
- READ_LATENCY=1: rdata updates and rvalid=1 after edge N, i.e. valid during cycle N+1.
- READ_LATENCY=2: the array output is captured in the stage-1 register at edge N. It moves to rdata at edge N+1, with rvalid=1 during cycle N+2.
- Back-to-back reads every cycle are supported at full throughput. Each accepted read yields exactly one rvalid cycle, in order.
- When rvalid=0, rdata holds its last value. It changes only when new read data arrives; it does not return to 0.

Read-during-write, same address, same edge
- RDW_MODE=0: the read returns pre-write contents.
- RDW_MODE=1: per byte, the read returns wdata byte i where wbe[i]=1 and the old byte elsewhere.
- Different addresses: independent, no interaction.

Other timing rules
- A write at edge N is visible to a read accepted at edge N+1 or later, in both modes.
- No wrap or overflow logic: addresses cover the full 2**ADDR_WIDTH range.
- Out-of-range addresses cannot occur.

Test Plan:
1. Reset and hold. rst=1 for 3 cycles with re=1, we=1, wbe=all ones → rvalid stays 0 and rdata=0. A subsequent read of that address returns its previous contents, not the write data.
2. Latency. READ_LATENCY=1 and 2: write 0xDEADBEEF to addr 3, then re=1 with raddr=3 at edge N → rdata=0xDEADBEEF with rvalid=1 at cycle N+1 (or N+2 respectively), for exactly one cycle. rdata then holds.
3. Byte enables. Write 0x11223344 to addr 5, then write 0xAABBCCDD with wbe=4'b0101 → reading addr 5 returns 0x11BB33DD.
4. Read-during-write. addr 7 holds 0x00000000. Same edge: we=1, wbe=4'b1100, wdata=0xFFFFFFFF, re=1, raddr=7 → RDW_MODE=0 returns 0x00000000, RDW_MODE=1 returns 0xFFFF0000. A next-cycle read of addr 7 returns 0xFFFF0000 in both modes.
5. Streaming. Fill addrs 0..15 with value = addr*0x01010101, then read 0..15 on consecutive cycles (READ_LATENCY=2) → 16 consecutive rvalid cycles carrying the values in order.
6. Reset mid-flight. READ_LATENCY=2: issue reads at edges N and N+1, assert rst during cycle N+1 → no rvalid is produced. After rst deasserts, a new read returns correct data after 2 cycles.

Source files
------------

// File: rtl/bram_sdp.sv
// ---------------------------------------------------------------------------
// bram_sdp -- simple dual-port block RAM (one write port, one read port,
// single clock) with per-byte write enables, selectable read-during-write
// behaviour, 1- or 2-cycle read latency and an rvalid strobe.
//
// Parameters
//   DATA_WIDTH    data width in bits, multiple of 8
//   ADDR_WIDTH    address width, depth = 2**ADDR_WIDTH words
//   READ_LATENCY  1 or 2 cycles from accepted read to rdata/rvalid
//   RDW_MODE      same-address read-during-write: 0 = old data,
//                 1 = new data (byte-merged bypass)
//
// Ports
//   clk     clock, all logic on rising edge
//   rst     synchronous active-high reset (clears read pipeline only)
//   we      write enable
//   wbe     byte-lane write enables, bit i covers wdata[8i+7:8i]
//   waddr   write address
//   wdata   write data
//   re      read enable
//   raddr   read address
//   rdata   read data, holds its value between reads
//   rvalid  one-cycle strobe marking new read data on rdata
// ---------------------------------------------------------------------------
module bram_sdp #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rvalid
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Parameter legality checks at elaboration time.
  if ((DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("bram_sdp: DATA_WIDTH must be a multiple of 8");
  end
  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("bram_sdp: READ_LATENCY must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Reset gates both ports: nothing is written or issued while rst is high.
  logic wr_en;
  logic rd_en;
  assign wr_en = we & ~rst;
  assign rd_en = re & ~rst;

  // -------------------------------------------------------------------------
  // Write port
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset branch; clearing a RAM would need one write
  // per word and would stop the tools mapping it onto block RAM, and its
  // contents are required to survive rst anyway.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read word, with optional same-address write bypass.
  // mem[raddr] sampled before the edge is the pre-write value, which is
  // exactly the "old data" result; new-data mode overlays written lanes.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word;

  // NOTE: rd_word gets its full default before any conditional overlay, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd_word = mem[raddr];
    if ((RDW_MODE == 1) && wr_en && (waddr == raddr)) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wbe[i]) begin
          rd_word[8*i +: 8] = wdata[8*i +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output pipeline
  // -------------------------------------------------------------------------
  if (READ_LATENCY == 1) begin : g_lat1
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_en;
        if (rd_en) begin
          rdata <= rd_word;
        end
      end
    end
  end else begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_data;
    logic                  s1_valid;

    // Stage 1 captures the array output; stage 2 is the registered output.
    // Reset clears both, which also flushes any read in flight.
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        rdata    <= '0;
        rvalid   <= 1'b0;
      end else begin
        s1_valid <= rd_en;
        if (rd_en) begin
          s1_data <= rd_word;
        end
        rvalid <= s1_valid;
        if (s1_valid) begin
          rdata <= s1_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_sdp.sv
// ---------------------------------------------------------------------------
// tb_bram_sdp -- directed bench for bram_sdp.
// Two instances share the same stimulus:
//   u_a : READ_LATENCY=1, RDW_MODE=0
//   u_b : READ_LATENCY=2, RDW_MODE=1
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, i.e. during the cycle that follows the edge.
// ---------------------------------------------------------------------------
module tb_bram_sdp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  wbe;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [3:0]  raddr;

  logic [31:0] rdata_a, rdata_b;
  logic        rvalid_a, rvalid_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bram_sdp #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (4),
    .READ_LATENCY(1),
    .RDW_MODE    (0)
  ) u_a (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wbe   (wbe),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata_a),
    .rvalid(rvalid_a)
  );

  bram_sdp #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (4),
    .READ_LATENCY(2),
    .RDW_MODE    (1)
  ) u_b (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .wbe   (wbe),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (raddr),
    .rdata (rdata_b),
    .rvalid(rvalid_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check both outputs of one instance at once.
  task automatic check_a(input string tag, input logic v, input logic [31:0] d);
    check({tag, " a.rvalid"}, {31'd0, rvalid_a}, {31'd0, v});
    check({tag, " a.rdata"},  rdata_a, d);
  endtask

  task automatic check_b(input string tag, input logic v, input logic [31:0] d);
    check({tag, " b.rvalid"}, {31'd0, rvalid_b}, {31'd0, v});
    check({tag, " b.rdata"},  rdata_b, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we    = 1'b0;
    wbe   = 4'h0;
    waddr = '0;
    wdata = '0;
    re    = 1'b0;
    raddr = '0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    we    = 1'b1;
    wbe   = be;
    waddr = a;
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();
    tick();
    check_a("reset", 1'b0, 32'h0);
    check_b("reset", 1'b0, 32'h0);

    // ---- 1. reset hold: ports ignored while rst=1, memory survives ----
    rst = 1'b0;
    write(4'd2, 32'h1234_5678, 4'hF);
    rst   = 1'b1;
    we    = 1'b1;
    wbe   = 4'hF;
    waddr = 4'd2;
    wdata = 32'hCAFE_F00D;
    re    = 1'b1;
    raddr = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_a("rst_hold", 1'b0, 32'h0);
      check_b("rst_hold", 1'b0, 32'h0);
    end
    rst = 1'b0;
    idle();
    re    = 1'b1;
    raddr = 4'd2;
    tick();
    re = 1'b0;
    check_a("post_rst_rd", 1'b1, 32'h1234_5678);
    check_b("post_rst_rd_c1", 1'b0, 32'h0);
    tick();
    check_a("post_rst_hold", 1'b0, 32'h1234_5678);
    check_b("post_rst_rd_c2", 1'b1, 32'h1234_5678);
    tick();
    check_b("post_rst_hold", 1'b0, 32'h1234_5678);

    // ---- 2. latency ----
    write(4'd3, 32'hDEAD_BEEF, 4'hF);
    re    = 1'b1;
    raddr = 4'd3;
    tick();
    re = 1'b0;
    check_a("lat_c1", 1'b1, 32'hDEAD_BEEF);
    check_b("lat_c1", 1'b0, 32'h1234_5678);
    tick();
    check_a("lat_c2", 1'b0, 32'hDEAD_BEEF);
    check_b("lat_c2", 1'b1, 32'hDEAD_BEEF);
    tick();
    check_b("lat_c3", 1'b0, 32'hDEAD_BEEF);

    // ---- 3. byte enables, including an all-zero-wbe no-op write ----
    write(4'd5, 32'h1122_3344, 4'hF);
    write(4'd5, 32'hAABB_CCDD, 4'b0101);
    write(4'd5, 32'h0000_0000, 4'b0000);
    re    = 1'b1;
    raddr = 4'd5;
    tick();
    re = 1'b0;
    check_a("wbe_c1", 1'b1, 32'h11BB_33DD);
    tick();
    check_b("wbe_c2", 1'b1, 32'h11BB_33DD);

    // ---- 4. read-during-write, same address ----
    write(4'd7, 32'h0000_0000, 4'hF);
    we    = 1'b1;
    wbe   = 4'b1100;
    waddr = 4'd7;
    wdata = 32'hFFFF_FFFF;
    re    = 1'b1;
    raddr = 4'd7;
    tick();
    we = 1'b0;
    check_a("rdw_same", 1'b1, 32'h0000_0000);
    tick();
    re = 1'b0;
    check_a("rdw_next", 1'b1, 32'hFFFF_0000);
    check_b("rdw_same", 1'b1, 32'hFFFF_0000);
    tick();
    check_a("rdw_idle", 1'b0, 32'hFFFF_0000);
    check_b("rdw_next", 1'b1, 32'hFFFF_0000);

    // Different addresses on the same edge do not interact.
    we    = 1'b1;
    wbe   = 4'hF;
    waddr = 4'd8;
    wdata = 32'h0123_4567;
    re    = 1'b1;
    raddr = 4'd3;
    tick();
    idle();
    check_a("rdw_diff", 1'b1, 32'hDEAD_BEEF);
    tick();
    check_b("rdw_diff", 1'b1, 32'hDEAD_BEEF);

    // ---- 5. streaming, full throughput ----
    for (int i = 0; i < 16; i++) begin
      write(4'(i), 32'h0101_0101 * 32'(i), 4'hF);
    end
    for (int i = 0; i < 16; i++) begin
      re    = 1'b1;
      raddr = 4'(i);
      tick();
      check_a($sformatf("stream%0d", i), 1'b1, 32'h0101_0101 * 32'(i));
      if (i == 0) begin
        check_b("stream0", 1'b0, 32'hDEAD_BEEF);
      end else begin
        check_b($sformatf("stream%0d", i), 1'b1, 32'h0101_0101 * 32'(i - 1));
      end
    end
    re = 1'b0;
    tick();
    check_a("stream_end", 1'b0, 32'h0F0F_0F0F);
    check_b("stream15", 1'b1, 32'h0F0F_0F0F);
    tick();
    check_b("stream_end", 1'b0, 32'h0F0F_0F0F);

    // ---- 6. reset mid-flight ----
    re    = 1'b1;
    raddr = 4'd4;
    tick();                       // edge N: read accepted
    check_a("flush_n", 1'b1, 32'h0404_0404);
    check_b("flush_n", 1'b0, 32'h0F0F_0F0F);
    rst   = 1'b1;
    raddr = 4'd6;
    tick();                       // edge N+1: rst sampled, pipeline flushed
    check_a("flush_n1", 1'b0, 32'h0);
    check_b("flush_n1", 1'b0, 32'h0);
    rst = 1'b0;
    re  = 1'b0;
    tick();
    check_b("flush_n2", 1'b0, 32'h0);
    tick();
    check_b("flush_n3", 1'b0, 32'h0);
    re    = 1'b1;
    raddr = 4'd9;
    tick();
    re = 1'b0;
    check_a("after_flush", 1'b1, 32'h0909_0909);
    check_b("after_flush_c1", 1'b0, 32'h0);
    tick();
    check_b("after_flush_c2", 1'b1, 32'h0909_0909);
    tick();
    check_b("after_flush_c3", 1'b0, 32'h0909_0909);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
